imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; SHALL support 32 and 64 only.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage can accept; a transfer occurs when in_valid and in_ready are both high.
REQ-008 in_inst  input  32  raw RV32 instruction word.
REQ-009 in_tag  input  TAG_W  opaque sideband (e.g. PC index), passed through unchanged.
REQ-010 out_valid  output  1  decoded entry valid.
REQ-011 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-012 out_imm  output  XLEN  decoded immediate.
REQ-013 out_fmt  output  3  format code: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-014 out_illegal  output  1  entry has an unrecognised encoding.
REQ-015 out_tag  output  TAG_W  tag of the presented entry.
REQ-016 illegal_cnt  output  8  saturating count of accepted illegal instructions.

Function
REQ-017 Decode on inst[6:2]: branch 11000 -> B; load 00000, arith-I 00100, jalr 11001, system 11100 -> I; store 01000 -> S; lui 01101, auipc 00101 -> U; jal 11011 -> J; arith-R 01100 -> R with imm 0.
REQ-018 I/S/B/J immediates SHALL be sign-extended from inst[31] to XLEN; B and J SHALL have bit 0 = 0; U = {inst[31:12], 12'b0} sign-extended from bit 31 to XLEN.
REQ-019 inst[1:0] != 2'b11 or any other opcode SHALL set out_illegal=1, out_imm=0, out_fmt=0.
REQ-020 Decode SHALL be computed at acceptance and stored; out_imm/out_fmt/out_illegal/out_tag SHALL come directly from registers, with no combinational path from in_* to out_*.
REQ-021 Buffering is a 2-entry skid buffer with states EMPTY, ONE, FULL; in_ready SHALL be a registered signal equal to (state != FULL).
REQ-022 Transitions: EMPTY+accept -> ONE; ONE+accept+no drain -> FULL; ONE+drain+no accept -> EMPTY; ONE+accept+drain -> ONE; FULL+drain -> ONE; otherwise hold.
REQ-023 Latency: an entry accepted in cycle N SHALL appear on out_* in cycle N+1 when the stage was EMPTY.
REQ-024 Order SHALL be preserved; output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 flush SHALL set state to EMPTY next cycle and override a simultaneous accept (the entry is dropped and not counted); in_ready SHALL be 1 the cycle after flush.
REQ-026 illegal_cnt SHALL increment on each accepted illegal entry, saturate at 255, and be unaffected by flush.

Reset
REQ-027 On rst: state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0.
REQ-028 rst SHALL have priority over flush and over any handshake; entries in flight are discarded.

Configuration
REQ-029 Macro IMM_GEN_CSR_ZIMM_EN: when defined, system opcode with funct3 in {101,110,111} SHALL yield out_imm = inst[19:15] zero-extended to XLEN and out_fmt=6.
REQ-030 Without IMM_GEN_CSR_ZIMM_EN, every system opcode SHALL decode as I-type, and out_fmt=6 SHALL never be produced.

Verification
REQ-031 XLEN=32, accept 0xFFF00093 -> next cycle out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
REQ-032 XLEN=64, accept 0x800000B7 -> out_imm=0xFFFFFFFF80000000, out_fmt=4; accept 0xFFDFF06F -> out_imm=0xFFFFFFFFFFFFFFFC, out_fmt=5.
REQ-033 out_ready=0, offer 3 instructions back-to-back -> 2 accepted, in_ready=0 from the cycle after the second accept; raise out_ready -> both delivered in order with tags intact, then the third is accepted.
REQ-034 Accept 0x00000013 then 0x00000000 -> second entry out_illegal=1, out_imm=0, illegal_cnt=1; 300 illegal accepts -> illegal_cnt=255.
REQ-035 FULL state, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entry not counted; rst mid-stream -> all outputs at reset values.
REQ-036 Accept 0x300FD073 -> with IMM_GEN_CSR_ZIMM_EN out_imm=0x1F, out_fmt=6; without it out_imm=0x300, out_fmt=1.

Source files
------------

// File: rtl/imm_gen_stage.sv
// RV32 immediate-decode stage behind a 2-entry skid buffer; decode happens at acceptance.
// Optional CSR zimm decoding is enabled by defining IMM_GEN_CSR_ZIMM_EN.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [7:0]       illegal_cnt,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
    localparam logic [2:0] FMT_Z = 3'd6;
`endif

    state_e            state_q, state_d;
    entry_t            head_q, head_d;
    entry_t            skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic [7:0]        cnt_q, cnt_d;

    logic signed [31:0] imm32;
    logic [2:0]         dec_fmt;
    logic               dec_illegal;
    entry_t             dec;
    logic               accept;
    logic               drain;

    // All formats fit in 32 signed bits; the cast widens to XLEN with sign extension.
    always_comb begin
        imm32       = '0;
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (in_inst[6:2])
                5'b11000: begin
                    dec_fmt = FMT_B;
                    imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                end
                5'b00000, 5'b00100, 5'b11001: begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                end
                5'b11100: begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
`ifdef IMM_GEN_CSR_ZIMM_EN
                    if (in_inst[14] && (in_inst[13:12] != 2'b00)) begin
                        dec_fmt = FMT_Z;
                        imm32   = {27'd0, in_inst[19:15]};
                    end
`endif
                end
                5'b01000: begin
                    dec_fmt = FMT_S;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                end
                5'b01101, 5'b00101: begin
                    dec_fmt = FMT_U;
                    imm32   = {in_inst[31:12], 12'd0};
                end
                5'b11011: begin
                    dec_fmt = FMT_J;
                    imm32   = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                end
                5'b01100: begin
                    dec_fmt = FMT_R;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dec.imm     = XLEN'(imm32);
        dec.fmt     = dec_fmt;
        dec.illegal = dec_illegal;
        dec.tag     = in_tag;
    end

    // A flushed cycle never accepts, so the dropped word is neither stored nor counted.
    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (accept && dec.illegal && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;
    assign out_tag     = head_q.tag;
    assign illegal_cnt = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus stream,
// each tracked by its own expected queue built from an independent decode model.
module tb_imm_gen_stage;

    localparam int TAG_W = 5;
    localparam int EW    = TAG_W + 1 + 3 + 64;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             rdy32, ov32, ill32;
    logic [31:0]      imm32;
    logic [2:0]       fmt32;
    logic [TAG_W-1:0] tag32;
    logic [7:0]       cnt32;
    logic [1:0]       st32;

    logic             rdy64, ov64, ill64;
    logic [63:0]      imm64;
    logic [2:0]       fmt64;
    logic [TAG_W-1:0] tag64;
    logic [7:0]       cnt64;
    logic [1:0]       st64;

    logic [EW-1:0] exp32_q[$];
    logic [EW-1:0] exp64_q[$];
    int            mcnt32;
    int            mcnt64;
    int            n_vec;
    int            n_err;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32),
        .illegal_cnt(cnt32), .dbg_state_o(st32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64),
        .illegal_cnt(cnt64), .dbg_state_o(st64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed expectation: {tag, illegal, fmt[2:0], imm[63:0]}
    function automatic logic [EW-1:0] model(input logic [31:0] i, input logic [TAG_W-1:0] t);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] u32;
        logic signed [63:0] imm;
        logic [2:0]         fmt;
        logic               ill;
        imm = '0;
        fmt = 3'd0;
        ill = 1'b0;
        if (i[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (i[6:2])
                5'b11000: begin b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; imm = b13; fmt = 3'd3; end
                5'b00000, 5'b00100, 5'b11001: begin i12 = i[31:20]; imm = i12; fmt = 3'd1; end
                5'b11100: begin
                    i12 = i[31:20]; imm = i12; fmt = 3'd1;
`ifdef IMM_GEN_CSR_ZIMM_EN
                    if (i[14:12] == 3'b101 || i[14:12] == 3'b110 || i[14:12] == 3'b111) begin
                        imm = {59'd0, i[19:15]}; fmt = 3'd6;
                    end
`endif
                end
                5'b01000: begin i12 = {i[31:25], i[11:7]}; imm = i12; fmt = 3'd2; end
                5'b01101, 5'b00101: begin u32 = {i[31:12], 12'd0}; imm = u32; fmt = 3'd4; end
                5'b11011: begin j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; imm = j21; fmt = 3'd5; end
                5'b01100: begin imm = '0; fmt = 3'd0; end
                default: ill = 1'b1;
            endcase
        end
        return {t, ill, fmt, imm};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  w[6:0] = 7'b1100011;
            1:  w[6:0] = 7'b0000011;
            2:  w[6:0] = 7'b0010011;
            3:  w[6:0] = 7'b1100111;
            4:  w[6:0] = 7'b1110011;
            5:  w[6:0] = 7'b0100011;
            6:  w[6:0] = 7'b0110111;
            7:  w[6:0] = 7'b0010111;
            8:  w[6:0] = 7'b1101111;
            9:  w[6:0] = 7'b0110011;
            10: w[1:0] = 2'($urandom_range(0, 2));
            default: w[6:0] = 7'b1111111;
        endcase
        return w;
    endfunction

    task automatic monitor();
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                exp32_q.delete();
                exp64_q.delete();
                if (rst) begin
                    mcnt32 = 0;
                    mcnt64 = 0;
                end
            end else begin
                if (ov32) begin
                    n_vec++;
                    if (exp32_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb32_unexpected: got tag=%0d imm=%h, expected no entry", tag32, imm32);
                    end else begin
                        e = exp32_q[0];
                        if ({tag32, ill32, fmt32, imm32} !== {e[EW-1:68], e[67], e[66:64], e[31:0]}) begin
                            n_err++;
                            $display("FAIL sb32_entry: got tag=%0d ill=%b fmt=%0d imm=%h, expected tag=%0d ill=%b fmt=%0d imm=%h",
                                     tag32, ill32, fmt32, imm32, e[EW-1:68], e[67], e[66:64], e[31:0]);
                        end
                        if (out_ready) void'(exp32_q.pop_front());
                    end
                end
                if (ov64) begin
                    n_vec++;
                    if (exp64_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb64_unexpected: got tag=%0d imm=%h, expected no entry", tag64, imm64);
                    end else begin
                        e = exp64_q[0];
                        if ({tag64, ill64, fmt64, imm64} !== e) begin
                            n_err++;
                            $display("FAIL sb64_entry: got tag=%0d ill=%b fmt=%0d imm=%h, expected tag=%0d ill=%b fmt=%0d imm=%h",
                                     tag64, ill64, fmt64, imm64, e[EW-1:68], e[67], e[66:64], e[63:0]);
                        end
                        if (out_ready) void'(exp64_q.pop_front());
                    end
                end
                e = model(in_inst, in_tag);
                if (in_valid && rdy32) begin
                    exp32_q.push_back(e);
                    if (e[67] && mcnt32 < 255) mcnt32++;
                end
                if (in_valid && rdy64) begin
                    exp64_q.push_back(e);
                    if (e[67] && mcnt64 < 255) mcnt64++;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
        int n;
        in_valid = 1'b1; in_inst = inst; in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!(rdy32 && rdy64) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%b/%b after %0d cycles, expected 1", rdy32, rdy64, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++;
        if ({ov32, rdy32, imm32, fmt32, ill32, tag32, cnt32, st32} !== {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 5'd0, 8'd0, 2'd0}) begin
            n_err++;
            $display("FAIL reset32: got ov=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d cnt=%0d st=%0d, expected 0 1 0 0 0 0 0 0",
                     ov32, rdy32, imm32, fmt32, ill32, tag32, cnt32, st32);
        end
        n_vec++;
        if ({ov64, rdy64, imm64, fmt64, ill64, tag64, cnt64, st64} !== {1'b0, 1'b1, 64'd0, 3'd0, 1'b0, 5'd0, 8'd0, 2'd0}) begin
            n_err++;
            $display("FAIL reset64: got ov=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d cnt=%0d st=%0d, expected 0 1 0 0 0 0 0 0",
                     ov64, rdy64, imm64, fmt64, ill64, tag64, cnt64, st64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_i_type();
        out_ready = 1'b1;
        send(32'hFFF00093, 5'd1);
        @(negedge clk);
        n_vec++;
        if ({ov32, imm32, fmt32, ill32} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL i_type32: got ov=%b imm=%h fmt=%0d ill=%b, expected 1 ffffffff 1 0", ov32, imm32, fmt32, ill32);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_xlen64();
        out_ready = 1'b1;
        send(32'h800000B7, 5'd2);
        @(negedge clk);
        n_vec++;
        if ({imm64, fmt64, imm32} !== {64'hFFFFFFFF80000000, 3'd4, 32'h80000000}) begin
            n_err++;
            $display("FAIL lui64: got imm64=%h fmt=%0d imm32=%h, expected ffffffff80000000 4 80000000", imm64, fmt64, imm32);
        end
        @(posedge clk);
        #1;
        send(32'hFFDFF06F, 5'd3);
        @(negedge clk);
        n_vec++;
        if ({imm64, fmt64} !== {64'hFFFFFFFFFFFFFFFC, 3'd5}) begin
            n_err++;
            $display("FAIL jal64: got imm64=%h fmt=%0d, expected fffffffffffffffc 5", imm64, fmt64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_inst   = rand_inst();
            in_tag    = TAG_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((exp32_q.size() != 0 || exp64_q.size() != 0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        n_vec++;
        if (exp32_q.size() != 0 || exp64_q.size() != 0 || ov32 || ov64) begin
            n_err++;
            $display("FAIL random_drain: got pending=%0d/%0d ov=%b/%b, expected 0 0 0 0",
                     exp32_q.size(), exp64_q.size(), ov32, ov64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b0;
        tick(3);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 5'd10;
        @(negedge clk);
        n_vec++;
        if ({rdy32, rdy64} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_ready_first: got %b%b, expected 11", rdy32, rdy64);
        end
        @(posedge clk);
        #1;
        in_inst = 32'h00200113; in_tag = 5'd11;
        @(negedge clk);
        n_vec++;
        if ({rdy32, rdy64} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_ready_second: got %b%b, expected 11", rdy32, rdy64);
        end
        @(posedge clk);
        #1;
        in_inst = 32'h00300193; in_tag = 5'd12;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({rdy32, rdy64, ov32, ov64, tag32, st32} !== {2'b00, 2'b11, 5'd10, 2'd2}) begin
                n_err++;
                $display("FAIL b2b_full_hold: got rdy=%b%b ov=%b%b tag=%0d st=%0d, expected 00 11 10 2",
                         rdy32, rdy64, ov32, ov64, tag32, st32);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({tag32, tag64, rdy32} !== {5'd10, 5'd10, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_deliver_a: got tag=%0d/%0d rdy=%b, expected 10 10 0", tag32, tag64, rdy32);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if ({tag32, tag64, rdy32, rdy64} !== {5'd11, 5'd11, 2'b11}) begin
            n_err++;
            $display("FAIL b2b_deliver_b: got tag=%0d/%0d rdy=%b%b, expected 11 11 11", tag32, tag64, rdy32, rdy64);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ov32, ov64, tag32, tag64} !== {2'b11, 5'd12, 5'd12}) begin
            n_err++;
            $display("FAIL b2b_deliver_c: got ov=%b%b tag=%0d/%0d, expected 11 12 12", ov32, ov64, tag32, tag64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        send(32'h00100093, 5'd20);
        send(32'h00200113, 5'd21);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000000; in_tag = 5'd22;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ov32, ov64, rdy32, rdy64, cnt32, cnt64, st32} !== {2'b00, 2'b11, 8'd0, 8'd0, 2'd0}) begin
            n_err++;
            $display("FAIL flush_full: got ov=%b%b rdy=%b%b cnt=%0d/%0d st=%0d, expected 00 11 0 0 0",
                     ov32, ov64, rdy32, rdy64, cnt32, cnt64, st32);
        end
        @(posedge clk);
        #1;
        send(32'h00500293, 5'd23);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000000; in_tag = 5'd24;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ov32, ov64, rdy32, rdy64, cnt32, cnt64} !== {2'b00, 2'b11, 8'd0, 8'd0}) begin
            n_err++;
            $display("FAIL flush_accept: got ov=%b%b rdy=%b%b cnt=%0d/%0d, expected 00 11 0 0",
                     ov32, ov64, rdy32, rdy64, cnt32, cnt64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        do_reset();
        out_ready = 1'b1;
        send(32'h00000013, 5'd1);
        send(32'h00000000, 5'd2);
        @(negedge clk);
        n_vec++;
        if ({ov32, ill32, imm32, fmt32, cnt32, cnt64} !== {1'b1, 1'b1, 32'd0, 3'd0, 8'd1, 8'd1}) begin
            n_err++;
            $display("FAIL illegal_first: got ov=%b ill=%b imm=%h fmt=%0d cnt=%0d/%0d, expected 1 1 0 0 1 1",
                     ov32, ill32, imm32, fmt32, cnt32, cnt64);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 300; k++) begin
            w = $urandom;
            w[1:0] = 2'($urandom_range(0, 2));
            send(w, TAG_W'(k));
            if (k == 252) begin
                n_vec++;
                if ({cnt32, cnt64} !== {8'd254, 8'd254}) begin
                    n_err++;
                    $display("FAIL illegal_cnt_254: got %0d/%0d, expected 254", cnt32, cnt64);
                end
            end
        end
        n_vec++;
        if ({cnt32, cnt64} !== {8'd255, 8'd255} || mcnt32 != 255) begin
            n_err++;
            $display("FAIL illegal_cnt_sat: got %0d/%0d, expected 255 (model %0d)", cnt32, cnt64, mcnt32);
        end
    endtask

    task automatic test_zimm();
        out_ready = 1'b1;
        send(32'h300FD073, 5'd5);
        @(negedge clk);
        n_vec++;
`ifdef IMM_GEN_CSR_ZIMM_EN
        if ({imm32, fmt32, imm64, fmt64} !== {32'h1F, 3'd6, 64'h1F, 3'd6}) begin
            n_err++;
            $display("FAIL zimm_on: got imm=%h/%h fmt=%0d/%0d, expected 1f 6", imm32, imm64, fmt32, fmt64);
        end
`else
        if ({imm32, fmt32, imm64, fmt64} !== {32'h300, 3'd1, 64'h300, 3'd1}) begin
            n_err++;
            $display("FAIL zimm_off: got imm=%h/%h fmt=%0d/%0d, expected 300 1", imm32, imm64, fmt32, fmt64);
        end
`endif
        @(posedge clk);
        #1;
        send(32'h30001073, 5'd6);
        @(negedge clk);
        n_vec++;
        if ({imm32, fmt32} !== {32'h300, 3'd1}) begin
            n_err++;
            $display("FAIL csrrw_i: got imm=%h fmt=%0d, expected 300 1", imm32, fmt32);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rst_midstream();
        out_ready = 1'b0;
        send(32'h00000000, 5'd7);
        send(32'h00700393, 5'd8);
        in_valid = 1'b1; in_inst = 32'h00000001; in_tag = 5'd9;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ov32, rdy32, imm32, fmt32, ill32, tag32, cnt32} !== {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 5'd0, 8'd0}) begin
            n_err++;
            $display("FAIL rst_mid32: got ov=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d cnt=%0d, expected 0 1 0 0 0 0 0",
                     ov32, rdy32, imm32, fmt32, ill32, tag32, cnt32);
        end
        n_vec++;
        if ({ov64, rdy64, imm64, fmt64, ill64, tag64, cnt64} !== {1'b0, 1'b1, 64'd0, 3'd0, 1'b0, 5'd0, 8'd0}) begin
            n_err++;
            $display("FAIL rst_mid64: got ov=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%0d cnt=%0d, expected 0 1 0 0 0 0 0",
                     ov64, rdy64, imm64, fmt64, ill64, tag64, cnt64);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; mcnt32 = 0; mcnt64 = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_i_type();
        test_xlen64();
        test_random();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_zimm();
        test_rst_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
